// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared BCD constants, FSM state type and digit check
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } bcd_state_e;

  function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] digit);
    return digit <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - one reverse double-dabble digit step: subtract 3 when digit >= 8
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic [BCD_DIGIT_W-1:0] adjusted
);

  assign adjusted = digit[3] ? (digit - 4'd3) : digit;

endmodule

// File: rtl/bcd_to_binary_seq.sv
// rtl/bcd_to_binary_seq.sv - sequential BCD-to-binary converter, one shift/adjust step per clock
// Optional invalid-digit detection: BCD_TO_BIN_ERR_EN
module bcd_to_binary_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [BCD_DIGIT_W*DIGITS-1:0] bcd_in,
  output logic                        busy,
  output logic                        done,
  output logic [BIN_W-1:0]            bin_out,
  output logic                        err
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [0:0] ST_IDLE = IDLE;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [0:0]       state;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_adj;
  logic [BIN_W-1:0] bin_sr;
  logic [BIN_W-1:0] bin_shift;
  logic [CNT_W-1:0] cnt;
  logic             last_iter;
  logic             in_valid;

  assign bcd_shift = {1'b0, bcd_sr[BCD_W-1:1]};
  assign bin_shift = {bcd_sr[0], bin_sr[BIN_W-1:1]};
  assign last_iter = (cnt == CNT_W'(BIN_W - 1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit    (bcd_shift[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .adjusted (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

`ifdef BCD_TO_BIN_ERR_EN
  logic err_q;
  logic err_pend;

  always_comb begin
    in_valid = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(bcd_in[i*BCD_DIGIT_W +: BCD_DIGIT_W])) in_valid = 1'b0;
    end
  end

  assign err = err_q;
`else
  assign in_valid = 1'b1;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bin_out <= '0;
      bcd_sr  <= '0;
      bin_sr  <= '0;
      cnt     <= '0;
`ifdef BCD_TO_BIN_ERR_EN
      err_q    <= 1'b0;
      err_pend <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy  <= 1'b1;
            state <= ST_RUN;
            if (in_valid) begin
              bcd_sr <= bcd_in;
              bin_sr <= '0;
              cnt    <= '0;
            end
`ifdef BCD_TO_BIN_ERR_EN
            else begin
              err_pend <= 1'b1;
            end
`endif
          end
        end
        default: begin
`ifdef BCD_TO_BIN_ERR_EN
          // Rejected input: spend one cycle in RUN so the report lands one edge after acceptance
          if (err_pend) begin
            err_pend <= 1'b0;
            err_q    <= 1'b1;
            bin_out  <= '0;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else
`endif
          begin
            bcd_sr <= bcd_adj;
            bin_sr <= bin_shift;
            cnt    <= cnt + CNT_W'(1);
            if (last_iter) begin
              bin_out <= bin_shift;
              done    <= 1'b1;
`ifdef BCD_TO_BIN_ERR_EN
              err_q   <= 1'b0;
`endif
              // A held start chains straight into the next conversion with no idle gap
              if (start && in_valid) begin
                bcd_sr <= bcd_in;
                bin_sr <= '0;
                cnt    <= '0;
              end else begin
                busy  <= 1'b0;
                state <= ST_IDLE;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// tb/tb_bcd_to_binary_seq.sv - self-checking bench for bcd_to_binary_seq against a decimal reference
module tb_bcd_to_binary_seq;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [4*DIGITS-1:0] bcd_in;
  logic              busy;
  logic              done;
  logic [BIN_W-1:0]  bin_out;
  logic              err;

  int total = 0;
  int bad   = 0;

  bcd_to_binary_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int bcd_value(input logic [4*DIGITS-1:0] b);
    int v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'((b >> (4 * i)) & 'hF);
    return v;
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      cyc++;
      if (done) return;
    end
    check("done_timeout", 0, 1);
  endtask

  task automatic convert(input logic [4*DIGITS-1:0] b, input string tag);
    int cyc;
    @(negedge clk);
    bcd_in = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = $urandom;
    check({tag, "_busy"}, busy, 1);
    wait_done(cyc);
    check({tag, "_lat"}, cyc, BIN_W);
    check({tag, "_val"}, bin_out, bcd_value(b));
    check({tag, "_err"}, err, 0);
    check({tag, "_idle"}, busy, 0);
    @(negedge clk);
    check({tag, "_pulse"}, done, 0);
  endtask

  initial begin
    int cyc;
    int n_done;
    int done_at;
    logic [BIN_W-1:0] done_val;
    logic [4*DIGITS-1:0] rb;

    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bin", bin_out, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;

    convert(12'h999, "c999");
    convert(12'h000, "c000");
    convert(12'h255, "c255");
    convert(12'h010, "c010");

    for (int t = 0; t < 20; t++) begin
      rb = '0;
      for (int d = 0; d < DIGITS; d++) rb[4*d +: 4] = 4'($urandom_range(0, 9));
      convert(rb, "rand");
    end

    // start re-pulsed mid-conversion must be ignored
    @(negedge clk);
    bcd_in = 12'h999;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    bcd_in = 12'h123;
    start  = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    n_done  = 0;
    done_at = 0;
    done_val = '0;
    for (int k = 4; k < 24; k++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        done_at  = k;
        done_val = bin_out;
      end
    end
    check("ign_count", n_done, 1);
    check("ign_at", done_at, BIN_W);
    check("ign_val", done_val, 999);

    // held start chains conversions back to back
    @(negedge clk);
    bcd_in = 12'h500;
    start  = 1'b1;
    @(negedge clk);
    check("chain_busy", busy, 1);
    bcd_in = 12'h001;
    wait_done(cyc);
    check("chain1_lat", cyc, BIN_W);
    check("chain1_val", bin_out, 500);
    start = 1'b0;
    check("chain_still_busy", busy, 1);
    wait_done(cyc);
    check("chain2_lat", cyc, BIN_W);
    check("chain2_val", bin_out, 1);

    // reset mid-conversion aborts without a done pulse
    @(negedge clk);
    bcd_in = 12'h999;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_bin", bin_out, 0);
    n_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) n_done++;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    convert(12'h642, "after_rst");

`ifdef BCD_TO_BIN_ERR_EN
    @(negedge clk);
    bcd_in = 12'h1A3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("inv_done", done, 1);
    check("inv_err", err, 1);
    check("inv_bin", bin_out, 0);
    check("inv_busy", busy, 0);
    convert(12'h042, "after_inv");
`else
    @(negedge clk);
    bcd_in = 12'h1A3;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    check("inv_lat", cyc, BIN_W);
    check("inv_err", err, 0);
    convert(12'h042, "after_inv");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
